// File: rtl/issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// issue_ctrl_pkg
// Shared types and rules for the dual-issue scheduler.
//   decode_data_t : one decoded instruction as it leaves decode
//   issue_ptr_t   : queue pointer for the default queue depth
//   ISSUE_DEPTH   : default queue depth
//   pair_ok()     : may N issue together with H (the pairing rules only;
//                   occupancy is handled by the caller)
// ---------------------------------------------------------------------------
package issue_ctrl_pkg;

  localparam int ISSUE_DEPTH = 8;

  typedef logic [$clog2(ISSUE_DEPTH)-1:0] issue_ptr_t;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       memread;
    logic       memwrite;
    logic       mul;
    logic       div;
    logic [1:0] cp0_ctl;
  } ctl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rdst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    ctl_t        ctl;
  } decode_data_t;

  function automatic logic is_branch(input decode_data_t d);
    return d.ctl.branch | d.ctl.jump;
  endfunction

  function automatic logic is_mem(input decode_data_t d);
    return d.ctl.memread | d.ctl.memwrite;
  endfunction

  // Mul/div and CP0/privileged ops always issue alone.
  function automatic logic is_solo(input decode_data_t d);
    return d.ctl.mul | d.ctl.div | (d.ctl.cp0_ctl != 2'b00);
  endfunction

  // A branch/jump in H always drags its delay slot along with it; a RAW
  // hazard there is resolved by forwarding in the next stage.
  function automatic logic pair_ok(input decode_data_t h, input decode_data_t n);
    logic raw;
    if (is_branch(h)) return 1'b1;
    raw = (h.rdst != 5'd0) && ((h.rdst == n.ra1) || (h.rdst == n.ra2));
    return !(raw || (is_mem(h) && is_mem(n)) || is_solo(h) || is_solo(n) || is_branch(n));
  endfunction

endpackage

// File: rtl/issue_ctrl_pair_check.sv
// ---------------------------------------------------------------------------
// issue_pair_check
// Combinational evaluation of the two oldest queue entries.
//   i_head      : entry at head (H, oldest)
//   i_next      : entry at head+1 (N)
//   i_count     : current queue occupancy
//   o_issuable1 : H may issue this cycle
//   o_issuable0 : N may issue together with H this cycle
// ---------------------------------------------------------------------------
module issue_pair_check
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH = ISSUE_DEPTH
) (
  input  decode_data_t               i_head,
  input  decode_data_t               i_next,
  input  logic [$clog2(DEPTH):0]     i_count,
  output logic                       o_issuable1,
  output logic                       o_issuable0
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic w_haveOne;
  logic w_haveTwo;
  logic w_unusedBits;

  assign w_haveOne = (i_count >= CW'(1));
  assign w_haveTwo = (i_count >= CW'(2));

  // A branch/jump is held until its delay slot is in the queue so the
  // two always leave together.
  assign o_issuable1 = w_haveOne && !(is_branch(i_head) && !w_haveTwo);

  assign o_issuable0 = w_haveTwo && o_issuable1 && pair_ok(i_head, i_next);

  // Fields that play no part in the pairing decision.
  assign w_unusedBits = ^{i_head.valid, i_head.pc, i_head.ra1, i_head.ra2,
                          i_next.valid, i_next.pc, i_next.rdst};

endmodule

// File: rtl/issue_ctrl.sv
// ---------------------------------------------------------------------------
// issue_ctrl
// Dual-issue scheduler between decode and register-read/issue. Decoded
// instructions are queued in a circular buffer and issued in order, up to
// two per cycle, subject to the pairing rules in issue_ctrl_pkg.
//   clk         : clock, all state on rising edge
//   resetn      : synchronous active-low reset
//   in_data     : decoded pair from decode, slot 1 older, per-slot valid
//   in_ready    : queue has room for a full pair this cycle
//   out_data    : issue pair, slot 1 older, valid mirrors out_valid
//   out_valid   : per-slot issue valid (2'b01 never occurs)
//   issue_ready : downstream takes the issue pair this cycle
//   flush       : redirect, drop everything queued and incoming
//   count       : current occupancy
// ---------------------------------------------------------------------------
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH = ISSUE_DEPTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  decode_data_t [1:0]     in_data,
  output logic                   in_ready,
  output decode_data_t [1:0]     out_data,
  output logic [1:0]             out_valid,
  input  logic                   issue_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decode_data_t   r_mem [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;

  logic [PW-1:0]  w_headNext1;
  logic [PW-1:0]  w_tailNext1;
  decode_data_t   w_head;
  decode_data_t   w_next;
  logic           w_iss1;
  logic           w_iss0;
  logic [1:0]     w_pushCnt;
  logic [1:0]     w_popCnt;

  assign w_headNext1 = r_head + PW'(1);
  assign w_tailNext1 = r_tail + PW'(1);
  assign w_head      = r_mem[r_head];
  assign w_next      = r_mem[w_headNext1];

  // Room is judged on the registered count only, so in_ready never
  // depends on this cycle's issue.
  assign in_ready = (r_count <= CW'(DEPTH - 2));
  assign count    = r_count;

  assign w_pushCnt = in_ready ? ({1'b0, in_data[1].valid} + {1'b0, in_data[0].valid}) : 2'd0;
  assign w_popCnt  = issue_ready ? ({1'b0, w_iss1} + {1'b0, w_iss0}) : 2'd0;

  issue_pair_check #(.DEPTH(DEPTH)) u_pairCheck (
    .i_head      (w_head),
    .i_next      (w_next),
    .i_count     (r_count),
    .o_issuable1 (w_iss1),
    .o_issuable0 (w_iss0)
  );

  assign out_valid = {w_iss1, w_iss0};

  // Present H and N as stored, with the valid bits replaced by the issue
  // decision so stale contents never look live.
  always_comb begin
    out_data[1]       = w_head;
    out_data[1].valid = w_iss1;
    out_data[0]       = w_next;
    out_data[0].valid = w_iss0;
  end

  // Queue storage. Invalid slots are squeezed out so the queue only ever
  // holds real instructions; contents need no reset because occupancy is
  // tracked by count alone.
  always_ff @(posedge clk) begin
    if (in_ready && !flush) begin
      if (in_data[1].valid) begin
        r_mem[r_tail] <= in_data[1];
        if (in_data[0].valid) begin
          r_mem[w_tailNext1] <= in_data[0];
        end
      end else if (in_data[0].valid) begin
        r_mem[r_tail] <= in_data[0];
      end
    end
  end

  // Pointers and occupancy. Reset and flush both empty the queue and take
  // priority over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_popCnt);
      r_tail  <= r_tail + PW'(w_pushCnt);
      r_count <= r_count + CW'(w_pushCnt) - CW'(w_popCnt);
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_issue_ctrl
// Directed bench for issue_ctrl (DEPTH = 8) with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int K_ALU  = 0;
  localparam int K_LW   = 1;
  localparam int K_SW   = 2;
  localparam int K_MULT = 3;
  localparam int K_BEQ  = 4;

  logic               clk;
  logic               resetn;
  decode_data_t [1:0] in_data;
  logic               in_ready;
  decode_data_t [1:0] out_data;
  logic [1:0]         out_valid;
  logic               issue_ready;
  logic               flush;
  logic [3:0]         count;

  int numCompared;
  int numMismatched;

  decode_data_t nop;

  issue_ctrl #(.DEPTH(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .issue_ready (issue_ready),
    .flush       (flush),
    .count       (count)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic decode_data_t mkInst(input int kind, input logic [31:0] pc,
                                          input logic [4:0] rd, input logic [4:0] r1,
                                          input logic [4:0] r2);
    decode_data_t d;
    d       = '0;
    d.valid = 1'b1;
    d.pc    = pc;
    d.rdst  = rd;
    d.ra1   = r1;
    d.ra2   = r2;
    case (kind)
      K_LW:    d.ctl.memread  = 1'b1;
      K_SW:    d.ctl.memwrite = 1'b1;
      K_MULT:  d.ctl.mul      = 1'b1;
      K_BEQ:   d.ctl.branch   = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  // Independent ALU op: writes $1, reads $2/$3, so any two of them pair.
  function automatic decode_data_t alu(input logic [31:0] pc);
    return mkInst(K_ALU, pc, 5'd1, 5'd2, 5'd3);
  endfunction

  task automatic applyStimulus(input decode_data_t d1, input decode_data_t d0,
                               input logic ir, input logic fl);
    in_data[1]  = d1;
    in_data[0]  = d0;
    issue_ready = ir;
    flush       = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    nop           = '0;
    resetn        = 1'b0;
    applyStimulus(nop, nop, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // ---- reset state ----
    checkOutput("rst_count", count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);

    // ---- back-to-back fill, issue blocked ----
    for (int i = 0; i < 4; i++) begin
      checkOutput("fill_in_ready", in_ready, 1);
      applyStimulus(alu(2 * i), alu(2 * i + 1), 1'b0, 1'b0);
      tick();
      checkOutput("fill_count", count, 2 * (i + 1));
    end
    checkOutput("full_in_ready", in_ready, 0);
    applyStimulus(alu(100), alu(101), 1'b0, 1'b0);
    tick();
    checkOutput("full_drop_count", count, 8);
    checkOutput("full_out_valid", out_valid, 3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(nop, nop, 1'b1, 1'b0);
      checkOutput("drain_out_valid", out_valid, 3);
      checkOutput("drain_pc1", out_data[1].pc, 2 * i);
      checkOutput("drain_pc0", out_data[0].pc, 2 * i + 1);
      checkOutput("drain_valid1", out_data[1].valid, 1);
      tick();
    end
    checkOutput("drain_count", count, 0);
    checkOutput("empty_out_valid", out_valid, 0);

    // ---- RAW split: addu $3,$1,$2 ; addu $4,$3,$3 ----
    applyStimulus(mkInst(K_ALU, 10, 5'd3, 5'd1, 5'd2), mkInst(K_ALU, 11, 5'd4, 5'd3, 5'd3), 1'b0, 1'b0);
    tick();
    checkOutput("raw_out_valid", out_valid, 2);
    checkOutput("raw_valid0", out_data[0].valid, 0);
    checkOutput("raw_pc1", out_data[1].pc, 10);
    applyStimulus(nop, nop, 1'b1, 1'b0);
    tick();
    checkOutput("raw_next_valid", out_valid, 2);
    checkOutput("raw_next_pc1", out_data[1].pc, 11);
    checkOutput("raw_next_count", count, 1);
    tick();
    checkOutput("raw_done_count", count, 0);
    // writing $0 never creates a hazard
    applyStimulus(mkInst(K_ALU, 12, 5'd0, 5'd1, 5'd2), mkInst(K_ALU, 13, 5'd5, 5'd0, 5'd0), 1'b0, 1'b0);
    tick();
    checkOutput("r0_out_valid", out_valid, 3);
    applyStimulus(nop, nop, 1'b1, 1'b0);
    tick();
    checkOutput("r0_count", count, 0);

    // ---- branch hold: branch alone, then delay slot via slot 0 only ----
    applyStimulus(mkInst(K_BEQ, 20, 5'd31, 5'd1, 5'd2), nop, 1'b1, 1'b0);
    tick();
    checkOutput("br_hold_valid", out_valid, 0);
    checkOutput("br_hold_count", count, 1);
    applyStimulus(nop, mkInst(K_ALU, 21, 5'd6, 5'd31, 5'd0), 1'b1, 1'b0);
    tick();
    checkOutput("br_pair_valid", out_valid, 3);
    checkOutput("br_pair_pc1", out_data[1].pc, 20);
    checkOutput("br_pair_pc0", out_data[0].pc, 21);
    applyStimulus(nop, nop, 1'b1, 1'b0);
    tick();
    checkOutput("br_done_count", count, 0);

    // ---- structural: lw/sw ----
    applyStimulus(mkInst(K_LW, 30, 5'd5, 5'd29, 5'd0), mkInst(K_SW, 31, 5'd0, 5'd29, 5'd6), 1'b0, 1'b0);
    tick();
    checkOutput("mem_valid", out_valid, 2);
    applyStimulus(nop, nop, 1'b1, 1'b0);
    tick();
    checkOutput("mem_second_valid", out_valid, 2);
    checkOutput("mem_second_pc1", out_data[1].pc, 31);
    tick();
    checkOutput("mem_count", count, 0);

    // ---- structural: mult/ALU ----
    applyStimulus(mkInst(K_MULT, 32, 5'd0, 5'd4, 5'd5), alu(33), 1'b0, 1'b0);
    tick();
    checkOutput("mul_valid", out_valid, 2);
    applyStimulus(nop, nop, 1'b1, 1'b0);
    tick();
    checkOutput("mul_second_valid", out_valid, 2);
    checkOutput("mul_second_pc1", out_data[1].pc, 33);
    tick();
    checkOutput("mul_count", count, 0);

    // ---- structural: ALU/beq, beq then leads the next pair ----
    applyStimulus(alu(34), mkInst(K_BEQ, 35, 5'd0, 5'd1, 5'd2), 1'b0, 1'b0);
    tick();
    checkOutput("alubr_valid", out_valid, 2);
    applyStimulus(nop, nop, 1'b1, 1'b0);
    tick();
    checkOutput("alubr_held_valid", out_valid, 0);
    checkOutput("alubr_held_pc1", out_data[1].pc, 35);
    applyStimulus(nop, alu(36), 1'b1, 1'b0);
    tick();
    checkOutput("alubr_pair_valid", out_valid, 3);
    checkOutput("alubr_pair_pc0", out_data[0].pc, 36);
    applyStimulus(nop, nop, 1'b1, 1'b0);
    tick();
    checkOutput("alubr_count", count, 0);

    // ---- wrap: head = tail = 5 here; two singles then a pair at 7/0 ----
    applyStimulus(alu(50), nop, 1'b1, 1'b0);
    tick();
    checkOutput("wrap_a_pc1", out_data[1].pc, 50);
    applyStimulus(alu(51), nop, 1'b1, 1'b0);
    tick();
    checkOutput("wrap_b_valid", out_valid, 2);
    checkOutput("wrap_b_pc1", out_data[1].pc, 51);
    applyStimulus(alu(52), alu(53), 1'b1, 1'b0);
    tick();
    checkOutput("wrap_c_valid", out_valid, 3);
    checkOutput("wrap_c_pc1", out_data[1].pc, 52);
    checkOutput("wrap_c_pc0", out_data[0].pc, 53);
    checkOutput("wrap_c_count", count, 2);
    applyStimulus(nop, nop, 1'b1, 1'b0);
    tick();
    checkOutput("wrap_done_count", count, 0);

    // ---- advance head to 6, fill to 6, then flush with push and pop ----
    applyStimulus(alu(54), alu(55), 1'b1, 1'b0);
    tick();
    applyStimulus(alu(56), alu(57), 1'b1, 1'b0);
    tick();
    applyStimulus(alu(58), nop, 1'b1, 1'b0);
    tick();
    applyStimulus(nop, nop, 1'b1, 1'b0);
    tick();
    checkOutput("adv_count", count, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(alu(60 + 2 * i), alu(61 + 2 * i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("pre_flush_count", count, 6);
    checkOutput("pre_flush_pc1", out_data[1].pc, 60);
    applyStimulus(alu(70), alu(71), 1'b1, 1'b1);
    tick();
    applyStimulus(nop, nop, 1'b0, 1'b0);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_out_valid", out_valid, 0);
    checkOutput("flush_in_ready", in_ready, 1);

    // ---- count = DEPTH-1: no room even with a pop pending ----
    for (int i = 0; i < 3; i++) begin
      applyStimulus(alu(80 + 2 * i), alu(81 + 2 * i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(alu(86), nop, 1'b0, 1'b0);
    tick();
    checkOutput("m1_count", count, 7);
    applyStimulus(alu(90), alu(91), 1'b1, 1'b0);
    checkOutput("m1_in_ready", in_ready, 0);
    tick();
    checkOutput("m1_pop_count", count, 5);
    checkOutput("m1_pop_pc1", out_data[1].pc, 82);

    // ---- reset mid-operation with count = 5 ----
    resetn = 1'b0;
    applyStimulus(alu(92), alu(93), 1'b1, 1'b0);
    tick();
    resetn = 1'b1;
    applyStimulus(nop, nop, 1'b0, 1'b0);
    checkOutput("mrst_count", count, 0);
    checkOutput("mrst_out_valid", out_valid, 0);
    checkOutput("mrst_in_ready", in_ready, 1);
    applyStimulus(alu(94), alu(95), 1'b0, 1'b0);
    tick();
    checkOutput("mrst_new_valid", out_valid, 3);
    checkOutput("mrst_new_pc1", out_data[1].pc, 94);
    checkOutput("mrst_new_pc0", out_data[0].pc, 95);
    applyStimulus(nop, nop, 1'b1, 1'b0);
    tick();
    checkOutput("mrst_done_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
